stack_pointer_unit: RTL and testbench

STACK_POINTER_UNIT -- requirements
Module: stack_pointer_unit

---
 rtl/sp_pkg.sv | 13 +
 rtl/sp_bound_check.sv | 41 ++++
 rtl/stack_pointer_unit.sv | 159 +++++++++++++++
 tb/tb_stack_pointer_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
// Shared types and constants for the stack pointer unit.
// Holds the controller state encoding and the growth-direction constants.
package sp_pkg;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    localparam logic DIR_DOWN = 1'b1;
    localparam logic DIR_UP   = 1'b0;

endpackage

// File: rtl/sp_bound_check.sv
// Next-address, next-pointer and legality computation for one push or pop.
// Uses one extra bit so that a carry or borrow shows up as a bound violation.
module sp_bound_check
    import sp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int STEP      = 1,
    parameter bit GROW_DOWN = 1'b1
) (
    input  logic [WIDTH-1:0] i_sp,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic             i_push,
    output logic [WIDTH-1:0] o_addr,
    output logic [WIDTH-1:0] o_next_sp,
    output logic             o_legal
);

    localparam logic DIR = GROW_DOWN ? DIR_DOWN : DIR_UP;
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic             w_dec;
    logic [WIDTH:0]   w_sp_x;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [WIDTH:0]   w_nxt;

    // Decrementing ops address the new slot, incrementing ops the old one.
    assign w_dec  = (DIR == DIR_DOWN) ? i_push : !i_push;
    assign w_sp_x = {1'b0, i_sp};
    assign w_sum  = w_sp_x + STEP_X;
    assign w_dif  = w_sp_x - STEP_X;
    assign w_nxt  = w_dec ? w_dif : w_sum;

    assign o_addr    = w_dec ? w_dif[WIDTH-1:0] : i_sp;
    assign o_next_sp = w_nxt[WIDTH-1:0];
    assign o_legal   = !w_nxt[WIDTH]
                     && (w_nxt[WIDTH-1:0] >= i_lo)
                     && (w_nxt[WIDTH-1:0] <= i_hi);

endmodule

// File: rtl/stack_pointer_unit.sv
// Bounded stack pointer with push/pop addressing and sticky fault flags.
// Register writes take precedence over push/pop; clear_fault loses to a new fault.
module stack_pointer_unit
    import sp_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               STEP      = 1,
    parameter bit               GROW_DOWN = 1'b1,
    parameter logic [WIDTH-1:0] RESET_SP  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             write,
    input  logic             write_lo,
    input  logic             write_hi,
    input  logic             push,
    input  logic             pop,
    input  logic             read_dbus,
    input  logic             clear_fault,
    output logic [WIDTH-1:0] abus_out,
    output logic [WIDTH-1:0] dbus_out,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic             illegal,
    output logic             fault
);

    logic [WIDTH-1:0] r_sp;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    state_t           r_state;
    logic             r_ovf;
    logic             r_unf;
    logic             r_ill;

    logic [WIDTH-1:0] w_push_addr;
    logic [WIDTH-1:0] w_push_nsp;
    logic             w_push_ok;
    logic [WIDTH-1:0] w_pop_addr;
    logic [WIDTH-1:0] w_pop_nsp;
    logic             w_pop_ok;

    logic [WIDTH-1:0] w_sp_n;
    logic [WIDTH-1:0] w_lo_n;
    logic [WIDTH-1:0] w_hi_n;
    state_t           w_state_n;
    logic             w_ovf_n;
    logic             w_unf_n;
    logic             w_ill_n;
    logic             w_err;
    logic             w_any_wr;

    sp_bound_check #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .GROW_DOWN(GROW_DOWN)
    ) u_push_chk (
        .i_sp     (r_sp),
        .i_lo     (r_lo),
        .i_hi     (r_hi),
        .i_push   (1'b1),
        .o_addr   (w_push_addr),
        .o_next_sp(w_push_nsp),
        .o_legal  (w_push_ok)
    );

    sp_bound_check #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .GROW_DOWN(GROW_DOWN)
    ) u_pop_chk (
        .i_sp     (r_sp),
        .i_lo     (r_lo),
        .i_hi     (r_hi),
        .i_push   (1'b0),
        .o_addr   (w_pop_addr),
        .o_next_sp(w_pop_nsp),
        .o_legal  (w_pop_ok)
    );

    assign w_any_wr = write | write_lo | write_hi;

    always_comb begin
        w_sp_n    = r_sp;
        w_lo_n    = r_lo;
        w_hi_n    = r_hi;
        w_state_n = r_state;
        w_ovf_n   = r_ovf;
        w_unf_n   = r_unf;
        w_ill_n   = r_ill;
        w_err     = 1'b0;
        if (write)    w_sp_n = din;
        if (write_lo) w_lo_n = din;
        if (write_hi) w_hi_n = din;
        if (!w_any_wr && (r_state == ST_READY)) begin
            if (push && pop) begin
                w_ill_n = 1'b1;
                w_err   = 1'b1;
            end else if (push) begin
                if (w_push_ok) begin
                    w_sp_n = w_push_nsp;
                end else begin
                    w_ovf_n = 1'b1;
                    w_err   = 1'b1;
                end
            end else if (pop) begin
                if (w_pop_ok) begin
                    w_sp_n = w_pop_nsp;
                end else begin
                    w_unf_n = 1'b1;
                    w_err   = 1'b1;
                end
            end
        end
        if (w_err) begin
            w_state_n = ST_FAULT;
        end else if (clear_fault) begin
            w_state_n = ST_READY;
            w_ovf_n   = 1'b0;
            w_unf_n   = 1'b0;
            w_ill_n   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp    <= RESET_SP;
            r_lo    <= '0;
            r_hi    <= '1;
            r_state <= ST_READY;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_ill   <= 1'b0;
        end else begin
            r_sp    <= w_sp_n;
            r_lo    <= w_lo_n;
            r_hi    <= w_hi_n;
            r_state <= w_state_n;
            r_ovf   <= w_ovf_n;
            r_unf   <= w_unf_n;
            r_ill   <= w_ill_n;
        end
    end

    // Address bus is released when neither or both requests are present.
    assign abus_out = (push ^ pop) ? (push ? w_push_addr : w_pop_addr) : 'z;
    assign dbus_out = read_dbus ? r_sp : 'z;

    assign full      = !w_push_ok;
    assign empty     = GROW_DOWN ? (r_sp == r_hi) : (r_sp == r_lo);
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign illegal   = r_ill;
    assign fault     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Scoreboard bench: a grow-down STEP=1 unit and a grow-up STEP=2 unit.
module tb_stack_pointer_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        write, write_lo, write_hi;
    logic        push, pop, read_dbus, clear_fault;

    wire  [15:0] abus, dbus;
    wire         full, empty, ovf, unf, ill, flt;
    wire  [15:0] abus2, dbus2;
    wire         full2, empty2, ovf2, unf2, ill2, flt2;

    logic [15:0] sb[$];
    logic [15:0] exp;
    logic [15:0] m_sp;
    int          n_pass = 0;
    int          n_tot  = 0;

    stack_pointer_unit dut (
        .clk(clk), .reset(reset), .din(din),
        .write(write), .write_lo(write_lo), .write_hi(write_hi),
        .push(push), .pop(pop), .read_dbus(read_dbus),
        .clear_fault(clear_fault),
        .abus_out(abus), .dbus_out(dbus),
        .full(full), .empty(empty),
        .overflow(ovf), .underflow(unf),
        .illegal(ill), .fault(flt)
    );

    stack_pointer_unit #(.STEP(2), .GROW_DOWN(1'b0)) dut_up (
        .clk(clk), .reset(reset), .din(din),
        .write(write), .write_lo(write_lo), .write_hi(write_hi),
        .push(push), .pop(pop), .read_dbus(read_dbus),
        .clear_fault(clear_fault),
        .abus_out(abus2), .dbus_out(dbus2),
        .full(full2), .empty(empty2),
        .overflow(ovf2), .underflow(unf2),
        .illegal(ill2), .fault(flt2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout act=running req=finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; din = '0;
        write = 0; write_lo = 0; write_hi = 0;
        push = 0; pop = 0; clear_fault = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; push = 1; clear_fault = 1; write = 1; din = 16'h1234;
        sb.push_back(16'h0000);
        sb.push_back(16'h0000);
        sb.push_back(16'h0001);
        sb.push_back(16'h0000);
        step();
        idle();
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL reset_sp act=%h req=%h", dbus, exp);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({12'b0, flt, ovf, unf, ill} !== exp)
            $display("FAIL reset_flags act=%b%b%b%b req=0000", flt, ovf, unf, ill);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({15'b0, full} !== exp) $display("FAIL reset_full act=%b req=1", full);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({15'b0, empty} !== exp) $display("FAIL reset_empty act=%b req=0", empty);
        else n_pass++;
        read_dbus = 0;
        sb.push_back(16'hzzzz);
        #1;
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL dbus_release act=%h req=%h", dbus, exp);
        else n_pass++;
        read_dbus = 1;
    endtask

    task automatic test_push_down();
        do_reset();
        din = 16'h0100; write = 1; write_hi = 1;
        step(); idle();
        din = 16'h00F0; write_lo = 1;
        step(); idle();
        sb.push_back(16'h0001);
        exp = sb.pop_front(); n_tot++;
        if ({15'b0, empty} !== exp) $display("FAIL empty_at_hi act=%b req=1", empty);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            push = 1;
            sb.push_back(16'h00FF - 16'(i));
            #1;
            exp = sb.pop_front(); n_tot++;
            if (abus !== exp) $display("FAIL push_addr%0d act=%h req=%h", i, abus, exp);
            else n_pass++;
            step();
            push = 0;
        end
        sb.push_back(16'h00FD);
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL push_sp act=%h req=%h", dbus, exp);
        else n_pass++;
        sb.push_back(16'h0000);
        exp = sb.pop_front(); n_tot++;
        if ({15'b0, empty} !== exp) $display("FAIL push_empty act=%b req=0", empty);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        din = 16'h00F0; write = 1; write_lo = 1;
        step(); idle();
        push = 1;
        sb.push_back(16'h00EF);
        sb.push_back(16'h0001);
        #1;
        exp = sb.pop_front(); n_tot++;
        if (abus !== exp) $display("FAIL ovf_addr act=%h req=%h", abus, exp);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({15'b0, full} !== exp) $display("FAIL full_at_lo act=%b req=1", full);
        else n_pass++;
        step();
        sb.push_back(16'h00F0);
        sb.push_back(16'h0003);
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL ovf_sp act=%h req=%h", dbus, exp);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({14'b0, ovf, flt} !== exp)
            $display("FAIL ovf_flags act=ovf%b/flt%b req=1/1", ovf, flt);
        else n_pass++;
        step();
        push = 0;
        sb.push_back(16'h00F0);
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL fault_push_ignored act=%h req=%h", dbus, exp);
        else n_pass++;
        clear_fault = 1;
        step(); idle();
        sb.push_back(16'h0000);
        exp = sb.pop_front(); n_tot++;
        if ({14'b0, ovf, flt} !== exp)
            $display("FAIL clear_fault act=ovf%b/flt%b req=0/0", ovf, flt);
        else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        din = 16'h0100; write = 1; write_hi = 1;
        step(); idle();
        pop = 1;
        sb.push_back(16'h0100);
        #1;
        exp = sb.pop_front(); n_tot++;
        if (abus !== exp) $display("FAIL unf_addr act=%h req=%h", abus, exp);
        else n_pass++;
        step(); idle();
        sb.push_back(16'h0100);
        sb.push_back(16'h0003);
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL unf_sp act=%h req=%h", dbus, exp);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({14'b0, unf, flt} !== exp)
            $display("FAIL unf_flags act=unf%b/flt%b req=1/1", unf, flt);
        else n_pass++;
        do_reset();
        push = 1;
        sb.push_back(16'hFFFF);
        #1;
        exp = sb.pop_front(); n_tot++;
        if (abus !== exp) $display("FAIL borrow_addr act=%h req=%h", abus, exp);
        else n_pass++;
        step(); idle();
        sb.push_back(16'h0000);
        sb.push_back(16'h0001);
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL borrow_sp act=%h req=%h", dbus, exp);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({15'b0, ovf} !== exp) $display("FAIL borrow_ovf act=%b req=1", ovf);
        else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        din = 16'h0050; write = 1;
        step(); idle();
        push = 1; pop = 1;
        sb.push_back(16'hzzzz);
        #1;
        exp = sb.pop_front(); n_tot++;
        if (abus !== exp) $display("FAIL both_abus act=%h req=%h", abus, exp);
        else n_pass++;
        step(); idle();
        sb.push_back(16'h0050);
        sb.push_back(16'h0003);
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL both_sp act=%h req=%h", dbus, exp);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({14'b0, ill, flt} !== exp)
            $display("FAIL both_flags act=ill%b/flt%b req=1/1", ill, flt);
        else n_pass++;
        clear_fault = 1;
        step(); idle();
        din = 16'h0040; write = 1; push = 1;
        step(); idle();
        sb.push_back(16'h0040);
        sb.push_back(16'h0000);
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL write_push_sp act=%h req=%h", dbus, exp);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({13'b0, ovf, ill, flt} !== exp)
            $display("FAIL write_push_flags act=%b%b%b req=000", ovf, ill, flt);
        else n_pass++;
    endtask

    task automatic test_grow_up();
        do_reset();
        din = 16'h0010; write = 1;
        step(); idle();
        push = 1;
        sb.push_back(16'h0010);
        #1;
        exp = sb.pop_front(); n_tot++;
        if (abus2 !== exp) $display("FAIL up_push_addr act=%h req=%h", abus2, exp);
        else n_pass++;
        step(); idle();
        sb.push_back(16'h0012);
        exp = sb.pop_front(); n_tot++;
        if (dbus2 !== exp) $display("FAIL up_push_sp act=%h req=%h", dbus2, exp);
        else n_pass++;
        pop = 1;
        sb.push_back(16'h0010);
        #1;
        exp = sb.pop_front(); n_tot++;
        if (abus2 !== exp) $display("FAIL up_pop_addr act=%h req=%h", abus2, exp);
        else n_pass++;
        step(); idle();
        sb.push_back(16'h0010);
        exp = sb.pop_front(); n_tot++;
        if (dbus2 !== exp) $display("FAIL up_pop_sp act=%h req=%h", dbus2, exp);
        else n_pass++;
    endtask

    task automatic test_reset_in_fault();
        do_reset();
        push = 1;
        step();
        sb.push_back(16'h0001);
        exp = sb.pop_front(); n_tot++;
        if ({15'b0, flt} !== exp) $display("FAIL pre_reset_fault act=%b req=1", flt);
        else n_pass++;
        reset = 1;
        step(); idle();
        sb.push_back(16'h0000);
        sb.push_back(16'h0000);
        exp = sb.pop_front(); n_tot++;
        if (dbus !== exp) $display("FAIL rst_fault_sp act=%h req=%h", dbus, exp);
        else n_pass++;
        exp = sb.pop_front(); n_tot++;
        if ({12'b0, flt, ovf, unf, ill} !== exp)
            $display("FAIL rst_fault_flags act=%b%b%b%b req=0000", flt, ovf, unf, ill);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        din = 16'h8000; write = 1;
        step(); idle();
        m_sp = 16'h8000;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                push = 1;
                m_sp = m_sp - 16'd1;
                sb.push_back(m_sp);
            end else begin
                pop = 1;
                sb.push_back(m_sp);
                m_sp = m_sp + 16'd1;
            end
            #1;
            exp = sb.pop_front(); n_tot++;
            if (abus !== exp) $display("FAIL b2b_addr%0d act=%h req=%h", i, abus, exp);
            else n_pass++;
            step(); idle();
            sb.push_back(m_sp);
            exp = sb.pop_front(); n_tot++;
            if (dbus !== exp) $display("FAIL b2b_sp%0d act=%h req=%h", i, dbus, exp);
            else n_pass++;
        end
    endtask

    initial begin
        idle();
        read_dbus = 1;
        step();
        test_reset();
        test_push_down();
        test_overflow();
        test_underflow();
        test_illegal();
        test_grow_up();
        test_reset_in_fault();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
